// File: rtl/clb_cfg_pkg.sv
// Shared types and helpers for the serially loaded LUT configuration chain.
// Default geometry constants mirror the block's default parameters.
package clb_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    CHECK  = 2'd2,
    COMMIT = 2'd3
  } cfg_state_e;

  // Ceiling log2, usable in constant expressions
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

  localparam int unsigned DEF_ADDR_BITS   = 4;
  localparam int unsigned DEF_NUM_OUT     = 2;
  localparam int unsigned DEF_CHAIN_WIDTH = 1;

  localparam int unsigned DEPTH    = 32'd1 << DEF_ADDR_BITS;
  localparam int unsigned MEM_SIZE = DEF_NUM_OUT * DEPTH;
  localparam int unsigned NBEATS   = MEM_SIZE / DEF_CHAIN_WIDTH;

endpackage

// File: rtl/cfg_shift_reg.sv
// Shadow shift register: shifts STEP bits in at the LSB end per enabled cycle
// and registers the STEP bits leaving the MSB end as the chain tail.
module cfg_shift_reg #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [STEP-1:0]  din,
  output logic [WIDTH-1:0] data,
  output logic [STEP-1:0]  tail
);

  logic [WIDTH-1:0] nxt;

  generate
    if (WIDTH > STEP) begin : g_shift
      assign nxt = {data[WIDTH-STEP-1:0], din};
    end else begin : g_single
      assign nxt = WIDTH'(din);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data <= '0;
      tail <= '0;
    end else if (en) begin
      tail <= data[WIDTH-1 -: STEP];
      data <= nxt;
    end
  end

endmodule

// File: rtl/block_config_chain.sv
// Double-buffered serial configuration memory for a multi-output LUT slice.
// Optional parity check on each load is enabled with CONFIG_PARITY_EN.
module block_config_chain
  import clb_cfg_pkg::*;
#(
  parameter int unsigned ADDR_BITS   = 4,
  parameter int unsigned NUM_OUT     = 2,
  parameter int unsigned CHAIN_WIDTH = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ADDR_BITS-1:0]   addr,
  output logic [NUM_OUT-1:0]     out,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [CHAIN_WIDTH-1:0] cfg_data,
  output logic [CHAIN_WIDTH-1:0] cfg_out,
  output logic                   cfg_done,
  output logic                   cfg_err
);

  localparam int unsigned N_DEPTH = 32'd1 << ADDR_BITS;
  localparam int unsigned N_MEM   = NUM_OUT * N_DEPTH;
  localparam int unsigned N_BEATS = N_MEM / CHAIN_WIDTH;
  localparam int unsigned CNT_W   = clog2(N_BEATS + 1);

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_SHIFT  = SHIFT;
  localparam logic [1:0] ST_COMMIT = COMMIT;
`ifdef CONFIG_PARITY_EN
  localparam logic [1:0] ST_CHECK  = CHECK;
  localparam logic [1:0] ST_LAST   = ST_CHECK;
`else
  localparam logic [1:0] ST_LAST   = ST_COMMIT;
`endif

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             accept_c;
  logic             shift_en_c;
  logic [N_MEM-1:0] shadow;
  logic [N_MEM-1:0] active;
`ifdef CONFIG_PARITY_EN
  logic             err_q, err_d;
  logic             par_q, par_d;
`endif

  assign accept_c = cfg_valid & ready_q;

  // The parity beat is consumed without disturbing the shadow
`ifdef CONFIG_PARITY_EN
  assign shift_en_c = accept_c && (state_q != ST_CHECK);
`else
  assign shift_en_c = accept_c;
`endif

  cfg_shift_reg #(
    .WIDTH (N_MEM),
    .STEP  (CHAIN_WIDTH)
  ) u_shadow (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (shift_en_c),
    .din   (cfg_data),
    .data  (shadow),
    .tail  (cfg_out)
  );

  // Next-state, beat counter and status logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
`ifdef CONFIG_PARITY_EN
    err_d   = err_q;
    par_d   = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          cnt_d   = CNT_W'(1);
          state_d = (N_BEATS == 1) ? ST_LAST : ST_SHIFT;
`ifdef CONFIG_PARITY_EN
          err_d   = 1'b0;
          par_d   = ^cfg_data;
`endif
        end
      end
      ST_SHIFT: begin
        if (accept_c) begin
          cnt_d = cnt_q + CNT_W'(1);
`ifdef CONFIG_PARITY_EN
          par_d = par_q ^ (^cfg_data);
`endif
          if (cnt_q == CNT_W'(N_BEATS - 1)) state_d = ST_LAST;
        end
      end
`ifdef CONFIG_PARITY_EN
      ST_CHECK: begin
        if (accept_c) begin
          if (cfg_data[0] == par_q) begin
            state_d = ST_COMMIT;
          end else begin
            err_d   = 1'b1;
            cnt_d   = '0;
            state_d = ST_IDLE;
          end
        end
      end
`endif
      ST_COMMIT: begin
        done_d  = 1'b1;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
    ready_d = (state_d != ST_COMMIT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      active  <= '0;
`ifdef CONFIG_PARITY_EN
      err_q   <= 1'b0;
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      if (state_q == ST_COMMIT) active <= shadow;
`ifdef CONFIG_PARITY_EN
      err_q   <= err_d;
      par_q   <= par_d;
`endif
    end
  end

  assign cfg_ready = ready_q;
  assign cfg_done  = done_q;
`ifdef CONFIG_PARITY_EN
  assign cfg_err   = err_q;
`else
  assign cfg_err   = 1'b0;
`endif

  // Each channel owns a DEPTH-bit slice of the active memory
  generate
    for (genvar k = 0; k < NUM_OUT; k++) begin : g_chan
      logic [N_DEPTH-1:0] chan;
      assign chan   = active[k*N_DEPTH +: N_DEPTH];
      assign out[k] = chan[addr];
    end
  endgenerate

endmodule
